// File: rtl/ser_link_pkg.sv
// Shared definitions for the serial link transmitter/receiver pair:
// FSM state encoding, frame field widths, terminal bit counts and the
// CRC32 generator polynomial used by the bit-serial CRC step.
package ser_link_pkg;

    localparam int DATA_BITS = 16;
    localparam int CRC_BITS  = 32;

    // Terminal values of the 5-bit bit counter in each serial phase.
    localparam logic [4:0] DATA_LAST = 5'(DATA_BITS - 1);
    localparam logic [4:0] CRC_LAST  = 5'(CRC_BITS - 1);

    // CRC32 generator polynomial, normal (MSB-first) form.
    localparam logic [CRC_BITS-1:0] CRC32_POLY = 32'h04C1_1DB7;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SYNC = 3'd1,
        DATA = 3'd2,
        CRC  = 3'd3,
        GAP  = 3'd4
    } state_e;

endpackage

// File: rtl/crc32_one_bit.sv
// One bit of an MSB-first CRC32 shift: feeds a single serial data bit into
// the running CRC. Shared with the receiver so both ends agree bit-for-bit.
module crc32_one_bit
    import ser_link_pkg::*;
(
    input  logic [CRC_BITS-1:0] crcIn,
    input  logic                data,
    output logic [CRC_BITS-1:0] crcOut
);

    logic feedback_s;

    // Feedback is the outgoing CRC MSB xor the incoming bit; on feedback the
    // shifted value is folded with the polynomial.
    always_comb begin
        feedback_s = crcIn[CRC_BITS-1] ^ data;
        if (feedback_s) begin
            crcOut = {crcIn[CRC_BITS-2:0], 1'b0} ^ CRC32_POLY;
        end else begin
            crcOut = {crcIn[CRC_BITS-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/ser_xmtr.sv
// Serial frame transmitter. Takes one 16-bit word over valid/ready, sends a
// one-cycle frame sync, then the word MSB-first, accumulating a bit-serial
// CRC32 seeded per frame. Build macro SER_XMTR_CRC_TRAILER_EN appends the
// final CRC (MSB first) as a 32-bit trailer after the data bits.
//
// After the last serial bit the FSM sits in GAP for GAP_CYCLES+1 cycles: the
// first of these carries the o_done pulse, the rest are the forced idle gap.
module ser_xmtr
    import ser_link_pkg::*;
#(
    parameter int GAP_CYCLES = 0
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [DATA_BITS-1:0] i_data,
    input  logic [CRC_BITS-1:0]  i_crc,
    input  logic                 i_vld,
    output logic                 o_rdy,
    output logic                 o_fs,
    output logic                 o_d,
    output logic [CRC_BITS-1:0]  o_crc,
    output logic                 o_done
);

    localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES);

    state_e                state_r;
    state_e                state_s;
    logic [4:0]            bit_cnt_r;
    logic [7:0]            gap_cnt_r;
    logic [DATA_BITS-1:0]  shift_r;
    logic [CRC_BITS-1:0]   crc_r;
    logic [CRC_BITS-1:0]   crc_step_s;
    logic [CRC_BITS-1:0]   o_crc_r;
    logic                  accept_s;
    logic                  o_fs_s;
    logic                  o_d_s;
    logic                  o_done_s;
    logic                  o_fs_r;
    logic                  o_d_r;
    logic                  o_done_r;

    assign o_rdy    = (state_r == IDLE) & ~i_rst;
    assign accept_s = i_vld & o_rdy;

    // The bit being launched onto o_d this edge is the MSB of the shifter.
    crc32_one_bit u_crc32_one_bit (
        .crcIn  (crc_r),
        .data   (shift_r[DATA_BITS-1]),
        .crcOut (crc_step_s)
    );

    // FSM state register with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state decode.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_s = SYNC;
                end else begin
                    state_s = IDLE;
                end
            end
            SYNC: begin
                state_s = DATA;
            end
            DATA: begin
                if (bit_cnt_r == DATA_LAST) begin
`ifdef SER_XMTR_CRC_TRAILER_EN
                    state_s = CRC;
`else
                    state_s = GAP;
`endif
                end else begin
                    state_s = DATA;
                end
            end
`ifdef SER_XMTR_CRC_TRAILER_EN
            CRC: begin
                if (bit_cnt_r == CRC_LAST) begin
                    state_s = GAP;
                end else begin
                    state_s = CRC;
                end
            end
`endif
            GAP: begin
                if (gap_cnt_r == GAP_LAST) begin
                    state_s = IDLE;
                end else begin
                    state_s = GAP;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Next values of the registered line outputs, one cycle ahead of the wire.
    always_comb begin
        o_fs_s   = 1'b0;
        o_d_s    = 1'b0;
        o_done_s = 1'b0;
        case (state_r)
            IDLE: begin
                o_fs_s = accept_s;
            end
            SYNC: begin
                o_d_s = shift_r[DATA_BITS-1];
            end
            DATA: begin
                if (bit_cnt_r != DATA_LAST) begin
                    o_d_s = shift_r[DATA_BITS-1];
                end else begin
`ifdef SER_XMTR_CRC_TRAILER_EN
                    o_d_s = crc_r[CRC_BITS-1];
`else
                    o_done_s = 1'b1;
`endif
                end
            end
`ifdef SER_XMTR_CRC_TRAILER_EN
            CRC: begin
                if (bit_cnt_r != CRC_LAST) begin
                    o_d_s = crc_r[CRC_BITS-1];
                end else begin
                    o_done_s = 1'b1;
                end
            end
`endif
            default: begin
                o_d_s = 1'b0;
            end
        endcase
    end

    // Datapath: word/seed capture, shifting, CRC accumulation and counters.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            bit_cnt_r <= 5'd0;
            gap_cnt_r <= 8'd0;
            shift_r   <= '0;
            crc_r     <= '0;
            o_crc_r   <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    bit_cnt_r <= 5'd0;
                    gap_cnt_r <= 8'd0;
                    if (accept_s) begin
                        shift_r <= i_data;
                        crc_r   <= i_crc;
                    end
                end
                SYNC: begin
                    shift_r   <= {shift_r[DATA_BITS-2:0], 1'b0};
                    crc_r     <= crc_step_s;
                    bit_cnt_r <= 5'd0;
                end
                DATA: begin
                    gap_cnt_r <= 8'd0;
                    if (bit_cnt_r != DATA_LAST) begin
                        shift_r   <= {shift_r[DATA_BITS-2:0], 1'b0};
                        crc_r     <= crc_step_s;
                        bit_cnt_r <= bit_cnt_r + 5'd1;
                    end else begin
                        o_crc_r   <= crc_r;
                        bit_cnt_r <= 5'd0;
`ifdef SER_XMTR_CRC_TRAILER_EN
                        // Trailer bit 31 is launched now; crc_r becomes its shifter.
                        crc_r     <= {crc_r[CRC_BITS-2:0], 1'b0};
`endif
                    end
                end
`ifdef SER_XMTR_CRC_TRAILER_EN
                CRC: begin
                    gap_cnt_r <= 8'd0;
                    crc_r     <= {crc_r[CRC_BITS-2:0], 1'b0};
                    if (bit_cnt_r != CRC_LAST) begin
                        bit_cnt_r <= bit_cnt_r + 5'd1;
                    end else begin
                        bit_cnt_r <= 5'd0;
                    end
                end
`endif
                GAP: begin
                    gap_cnt_r <= gap_cnt_r + 8'd1;
                end
                default: begin
                    bit_cnt_r <= 5'd0;
                    gap_cnt_r <= 8'd0;
                end
            endcase
        end
    end

    // Output registers so o_fs/o_d/o_done come straight from flops.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_fs_r   <= 1'b0;
            o_d_r    <= 1'b0;
            o_done_r <= 1'b0;
        end else begin
            o_fs_r   <= o_fs_s;
            o_d_r    <= o_d_s;
            o_done_r <= o_done_s;
        end
    end

    assign o_fs   = o_fs_r;
    assign o_d    = o_d_r;
    assign o_done = o_done_r;
    assign o_crc  = o_crc_r;

endmodule

// File: tb/tb_ser_xmtr.sv
// Self-checking bench for ser_xmtr. A scoreboard queue receives one record
// per accepted word; a negedge monitor pops it and predicts o_fs/o_d/o_done/
// o_rdy/o_crc cycle by cycle, and deserializes the line like the receiver.
module tb_ser_xmtr;

    localparam int GAP = 3;
`ifdef SER_XMTR_CRC_TRAILER_EN
    localparam bit TRL = 1'b1;
`else
    localparam bit TRL = 1'b0;
`endif
    localparam int DONE_K    = TRL ? 50 : 18;
    localparam int BUSY_LAST = DONE_K + GAP;
    localparam int PERIOD    = DONE_K + GAP + 1;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic [15:0] i_data = 16'h0000;
    logic [31:0] i_crc = 32'h0000_0000;
    logic        i_vld = 1'b0;
    logic        o_rdy;
    logic        o_fs;
    logic        o_d;
    logic [31:0] o_crc;
    logic        o_done;

    ser_xmtr #(.GAP_CYCLES(GAP)) dut (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_data (i_data),
        .i_crc  (i_crc),
        .i_vld  (i_vld),
        .o_rdy  (o_rdy),
        .o_fs   (o_fs),
        .o_d    (o_d),
        .o_crc  (o_crc),
        .o_done (o_done)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        int          a;
        logic [15:0] data;
        logic [31:0] crc;
    } frame_t;

    frame_t      sb_q[$];
    frame_t      cur;
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    bit          mon_en = 1'b0;
    bit          active = 1'b0;
    logic [31:0] exp_ocrc = 32'h0000_0000;
    logic [15:0] rx_word = 16'h0000;
    logic [31:0] rx_trl = 32'h0000_0000;

    // Cycle counter; cycle n is the period following the n-th rising edge.
    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", tag, cyc, got, exp);
        end
    endtask

    // Reference MSB-first CRC32 over a 16-bit word.
    function automatic logic [31:0] crc_gold(input logic [31:0] seed, input logic [15:0] d);
        logic [31:0] c;
        c = seed;
        for (int i = 15; i >= 0; i--) begin
            if (c[31] ^ d[i]) c = {c[30:0], 1'b0} ^ 32'h04C1_1DB7;
            else              c = {c[30:0], 1'b0};
        end
        return c;
    endfunction

    // Monitor: predict and compare every output once per cycle.
    always @(negedge i_clk) begin
        int   k;
        logic exp_fs, exp_d, exp_done, exp_rdy;
        if (mon_en) begin
            if (!active && sb_q.size() > 0 && cyc == sb_q[0].a + 1) begin
                cur    = sb_q.pop_front();
                active = 1'b1;
            end
            k        = cyc - cur.a;
            exp_fs   = 1'b0;
            exp_d    = 1'b0;
            exp_done = 1'b0;
            exp_rdy  = !i_rst;
            if (active) begin
                exp_rdy = 1'b0;
                if (k == 1) exp_fs = 1'b1;
                else if (k >= 2 && k <= 17) exp_d = cur.data[17-k];
                else if (TRL && k >= 18 && k <= 49) exp_d = cur.crc[49-k];
                if (k == DONE_K) exp_done = 1'b1;
                if (k == 18) exp_ocrc = cur.crc;
            end
            check("o_fs",   32'(o_fs),   32'(exp_fs));
            check("o_d",    32'(o_d),    32'(exp_d));
            check("o_done", 32'(o_done), 32'(exp_done));
            check("o_rdy",  32'(o_rdy),  32'(exp_rdy));
            check("o_crc",  o_crc,       exp_ocrc);
            if (active) begin
                if (k >= 2 && k <= 17) rx_word = {rx_word[14:0], o_d};
                if (k == 18) check("rx_word", 32'(rx_word), 32'(cur.data));
                if (TRL && k >= 18 && k <= 49) rx_trl = {rx_trl[30:0], o_d};
                if (TRL && k == 50) check("rx_trailer", rx_trl, o_crc);
                if (k == BUSY_LAST) active = 1'b0;
            end
            if (exp_rdy && i_vld) begin
                sb_q.push_back('{a: cyc, data: i_data, crc: crc_gold(i_crc, i_data)});
            end
            if (i_rst) begin
                active = 1'b0;
                sb_q.delete();
                exp_ocrc = 32'h0000_0000;
            end
        end
    end

    task automatic send(input logic [15:0] d, input logic [31:0] s, output int acc);
        i_data = d;
        i_crc  = s;
        i_vld  = 1'b1;
        acc    = -1;
        for (int n = 0; n < 200; n++) begin
            @(negedge i_clk);
            if (o_rdy) begin
                acc = cyc;
                break;
            end
        end
        if (acc < 0) check("accept_timeout", 32'(o_rdy), 32'd1);
        @(posedge i_clk);
        #1;
        i_vld = 1'b0;
    endtask

    task automatic wait_idle();
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge i_clk);
            if (o_rdy) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check("idle_timeout", 32'(o_rdy), 32'd1);
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        int          acc;
        int          accs[3];
        logic [15:0] words[3];
        logic [15:0] lb[3];
        words = '{16'h1357, 16'h2468, 16'hBEEF};
        lb    = '{16'h0000, 16'hFFFF, 16'h1234};

        // Reset, then monitor from the first post-reset cycle.
        @(posedge i_clk);
        #1;
        mon_en = 1'b1;
        repeat (2) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        @(posedge i_clk);
        #1;

        // Single frame with the test-plan word.
        send(16'hA5C3, 32'hFFFF_FFFF, acc);
        wait_idle();

        // Receiver loopback words.
        for (int i = 0; i < 3; i++) begin
            send(lb[i], 32'hFFFF_FFFF, acc);
            wait_idle();
        end

        // Trailer-relevant word.
        send(16'h8001, 32'hFFFF_FFFF, acc);
        wait_idle();

        // Back-to-back with i_vld held high.
        i_vld = 1'b1;
        i_crc = 32'h0BAD_F00D;
        for (int w = 0; w < 3; w++) begin
            i_data  = words[w];
            accs[w] = -1;
            for (int n = 0; n < 200; n++) begin
                @(negedge i_clk);
                if (o_rdy) begin
                    accs[w] = cyc;
                    break;
                end
            end
            @(posedge i_clk);
            #1;
        end
        i_vld = 1'b0;
        check("b2b_spacing0", 32'(accs[1] - accs[0]), 32'(PERIOD));
        check("b2b_spacing1", 32'(accs[2] - accs[1]), 32'(PERIOD));
        wait_idle();

        // Reset in the middle of DATA (asserted during cycle A+8).
        send(16'hC0DE, 32'hFFFF_FFFF, acc);
        repeat (7) @(posedge i_clk);
        #1;
        i_rst = 1'b1;
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        send(16'h5AA5, 32'h1234_5678, acc);
        wait_idle();

        // i_vld pulse while busy must be ignored.
        send(16'h0F0F, 32'hFFFF_FFFF, acc);
        repeat (4) @(posedge i_clk);
        #1;
        i_data = 16'hDEAD;
        i_vld  = 1'b1;
        @(posedge i_clk);
        #1;
        i_vld = 1'b0;
        wait_idle();
        check("sb_empty", 32'(sb_q.size()), 32'd0);

        repeat (5) @(posedge i_clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog cycle=%0d got=running expected=finished", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
